// File: rtl/bcd_xs3_sequencer_pkg.sv
// Shared FSM encoding and excess-3 constants for the BCD to XS3 sequencer.
// Also provides the index-width helper so all files size the digit counter identically.
package bcd_xs3_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] XS3_OFFSET  = 4'd3;
    localparam logic [3:0] XS3_INVALID = 4'hF;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_xs3_sequencer_if.sv
// Word-level handshake bundle between the sequencer and its neighbours.
// master drives words in and accepts results; slave is the sequencer itself.
interface bcd_xs3_sequencer_if #(parameter int NDIGITS = 4);

    logic                   in_valid;
    logic                   in_ready;
    logic [4*NDIGITS-1:0]   in_bcd;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*NDIGITS-1:0]   out_xs3;
    logic                   out_err;
    logic                   busy;

    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_xs3, out_err, busy
    );

    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_xs3, out_err, busy
    );

endinterface

// File: rtl/bcd_digit_xs3.sv
// Single-digit BCD to excess-3 converter, digits above 9 become XS3_INVALID.
// Latency: combinational. Backpressure: none, pure function.
module bcd_digit_xs3
    import bcd_xs3_sequencer_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] xs3,
    output logic       invalid
);

    always_comb begin
        invalid = (digit > 4'd9);
        xs3     = invalid ? XS3_INVALID : (digit + XS3_OFFSET);
    end

endmodule

// File: rtl/bcd_xs3_sequencer.sv
// Converts a packed BCD word to excess-3 one digit per cycle, LSD first.
// Latency: NDIGITS+1 cycles accept edge to out_valid; one word in flight at a time.
// Backpressure: holds the result in DONE until out_ready; in_ready only in IDLE.
module bcd_xs3_sequencer
    import bcd_xs3_sequencer_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    bcd_xs3_sequencer_if.slave      bus
);

    localparam int              IW   = idx_width(NDIGITS);
    localparam int              W    = 4 * NDIGITS;
    localparam logic [IW-1:0]   LAST = IW'(NDIGITS - 1);

    state_t         state;
    state_t         state_nxt;
    logic [IW-1:0]  idx;
    logic [W-1:0]   hold_bcd;
    logic [W-1:0]   res;
    logic [W-1:0]   res_nxt;
    logic           err_acc;
    logic [3:0]     cur_digit;
    logic [3:0]     cur_xs3;
    logic           cur_inv;
    logic           accept;
    logic           last_digit;
    logic           xfer;

    bcd_digit_xs3 u_digit (
        .digit   (cur_digit),
        .xs3     (cur_xs3),
        .invalid (cur_inv)
    );

    always_comb begin
        cur_digit           = hold_bcd[int'(idx)*4 +: 4];
        res_nxt             = res;
        res_nxt[int'(idx)*4 +: 4] = cur_xs3;
    end

    assign accept     = (state == IDLE) && bus.in_valid;
    assign last_digit = (state == CONV) && (idx == LAST);
    assign xfer       = (state == DONE) && bus.out_ready;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = CONV;
            CONV:    if (idx == LAST)   state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            hold_bcd    <= '0;
            res         <= '0;
            err_acc     <= 1'b0;
            bus.out_xs3 <= '0;
            bus.out_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                hold_bcd <= bus.in_bcd;
                idx      <= '0;
                res      <= '0;
                err_acc  <= 1'b0;
            end
            if (state == CONV) begin
                res     <= res_nxt;
                err_acc <= err_acc | cur_inv;
                if (!last_digit)
                    idx <= idx + 1'b1;
            end
            // Outputs load on the final digit edge so they are stable for all of DONE.
            if (last_digit) begin
                bus.out_xs3 <= res_nxt;
                bus.out_err <= err_acc | cur_inv;
            end
            if (xfer) begin
                bus.out_xs3 <= '0;
                bus.out_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_xs3_sequencer.sv
// Scoreboard bench for bcd_xs3_sequencer: accepted words push expected XS3/err, output handshakes pop.
module tb_bcd_xs3_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_xs3_sequencer_if #(.NDIGITS(4)) bus ();

    bcd_xs3_sequencer #(.NDIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    logic [16:0] exp_q[$];
    int          acc_cyc[$];
    int          vld_cyc[$];
    logic        prev_vld = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [15:0] w);
        logic [15:0] r;
        logic        e;
        logic [3:0]  d;
        r = '0;
        e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = w[i*4 +: 4];
            if (d > 4'd9) begin
                r[i*4 +: 4] = 4'hF;
                e = 1'b1;
            end else begin
                r[i*4 +: 4] = d + 4'd3;
            end
        end
        return {e, r};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.in_bcd));
                acc_cyc.push_back(cyc);
            end
            if (bus.out_valid && !prev_vld)
                vld_cyc.push_back(cyc);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_out", 32'd1, 32'd0);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    chk("sb_xs3", 32'(bus.out_xs3), 32'(e[15:0]));
                    chk("sb_err", 32'(bus.out_err), 32'(e[16]));
                end
                done_cnt++;
            end
            prev_vld = bus.out_valid;
        end else begin
            prev_vld = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_bcd   = w;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = bus.in_ready;
            n++;
            tick();
        end
        bus.in_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 100) begin
            tick();
            n++;
        end
        if (done_cnt < target) chk("done_timeout", 32'(done_cnt), 32'(target));
    endtask

    task automatic xfer(input logic [15:0] w);
        send(w);
        exp_done++;
        wait_done(exp_done);
    endtask

    initial begin
        logic [16:0] e;
        int          n;
        bus.in_valid  = 1'b0;
        bus.in_bcd    = '0;
        bus.out_ready = 1'b1;

        #12;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_out_err",   32'(bus.out_err),   32'd0);
        chk("rst_out_xs3",   32'(bus.out_xs3),   32'd0);
        tick();
        rst = 1'b0;

        // Nominal word, latency, single-cycle out_valid
        send(16'h1234);
        chk("conv_busy",     32'(bus.busy),     32'd1);
        chk("conv_in_ready", 32'(bus.in_ready), 32'd0);
        chk("conv_xs3_zero", 32'(bus.out_xs3),  32'd0);
        exp_done++;
        wait_done(exp_done);
        chk("one_cycle_vld", 32'(bus.out_valid), 32'd0);
        chk("idle_in_ready", 32'(bus.in_ready),  32'd1);
        if (vld_cyc.size() > 0 && acc_cyc.size() > 0)
            chk("latency", 32'(vld_cyc[0] - acc_cyc[0]), 32'd5);
        else
            chk("latency_missing", 32'd0, 32'd1);

        xfer(16'h0000);
        xfer(16'h9999);
        xfer(16'h12A4);
        xfer(16'h0001);

        // Backpressure in DONE with in_bcd churn
        bus.out_ready = 1'b0;
        e = model(16'h0987);
        send(16'h0987);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_bcd   = 16'($urandom);
            @(negedge clk);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_xs3",       32'(bus.out_xs3),   32'(e[15:0]));
            chk("bp_err",       32'(bus.out_err),   32'(e[16]));
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        exp_done++;
        tick();
        chk("bp_release_idle",  32'(bus.in_ready),  32'd1);
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_done_cnt",      32'(done_cnt),      32'(exp_done));

        // Reset in the second CONV cycle
        send(16'h5678);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy",      32'(bus.busy),      32'd0);
        chk("mid_rst_out_xs3",   32'(bus.out_xs3),   32'd0);
        chk("mid_rst_out_err",   32'(bus.out_err),   32'd0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_no_vld", 32'(bus.out_valid), 32'd0);
        end
        tick();
        xfer(16'h0042);

        // Back-to-back with in_valid held high
        n = acc_cyc.size();
        bus.in_valid = 1'b1;
        bus.in_bcd   = 16'h2468;
        for (int i = 0; i < 50 && acc_cyc.size() < n + 1; i++) tick();
        bus.in_bcd = 16'h1357;
        for (int i = 0; i < 50 && acc_cyc.size() < n + 2; i++) tick();
        bus.in_valid = 1'b0;
        if (acc_cyc.size() >= n + 2)
            chk("b2b_period", 32'(acc_cyc[n+1] - acc_cyc[n]), 32'd6);
        else
            chk("b2b_accept_timeout", 32'(acc_cyc.size()), 32'(n + 2));
        exp_done += 2;
        wait_done(exp_done);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_xs3_sequencer.md
BCD_XS3_SEQUENCER -- requirements
Module: bcd_xs3_sequencer

Interface
REQ-001 SHALL have parameter NDIGITS, default 4: number of packed BCD digits per word (range 1..8).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1: upstream word available.
REQ-005 SHALL have port in_ready, output, 1: block accepts a word this cycle.
REQ-006 SHALL have port in_bcd, input, 4*NDIGITS: packed BCD word; digit 0 in bits [3:0].
REQ-007 SHALL have port out_valid, output, 1: converted word available.
REQ-008 SHALL have port out_ready, input, 1: downstream accepts the word.
REQ-009 SHALL have port out_xs3, output, 4*NDIGITS: packed excess-3 result, same digit order as in_bcd.
REQ-010 SHALL have port out_err, output, 1: at least one input digit was greater than 9.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-012 SHALL implement the FSM states IDLE, CONV and DONE.
REQ-013 In IDLE, in_ready SHALL be 1; in every other state in_ready SHALL be 0.
REQ-014 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1. The block SHALL latch in_bcd, clear the digit index and error flag, and go to CONV.
REQ-015 In CONV, the block SHALL convert exactly one digit per cycle, least significant digit first, and write the result into the matching nibble of the result register.
REQ-016 Valid digits 0..9 SHALL map to digit+3, giving 4'h3..4'hC.
REQ-017 An invalid digit 10..15 SHALL map to 4'hF and SHALL set the sticky error flag.
REQ-018 After the edge that converts digit NDIGITS-1, the FSM SHALL move to DONE.
REQ-019 out_valid SHALL be high in the NDIGITS-th cycle after the accept cycle and later. Latency is NDIGITS+1 cycles from accept edge to first out_valid cycle.
REQ-020 In DONE, out_valid=1, and out_xs3 and out_err SHALL hold stable until the handshake.
REQ-021 An edge in DONE with out_ready=1 SHALL complete the transfer and return the FSM to IDLE. out_ready=0 SHALL keep the FSM in DONE indefinitely.
REQ-022 There SHALL be no bypass from DONE to CONV. in_ready rises only in the cycle after the output handshake, so the minimum word period is NDIGITS+2 cycles.
REQ-023 in_valid SHALL be ignored outside IDLE. in_bcd changes during CONV or DONE SHALL NOT affect the result.
REQ-024 out_ready SHALL be ignored outside DONE.
REQ-025 out_xs3 and out_err SHALL be registered outputs. out_xs3 SHALL read 0 outside DONE.
REQ-026 The digit index SHALL be ceil(log2(NDIGITS)) bits wide, minimum 1, and SHALL NOT wrap within a word.

Reset
REQ-027 Asserting rst SHALL immediately force state=IDLE, in_ready=1, out_valid=0, busy=0, out_err=0, out_xs3=0, and clear the index and all holding registers.
REQ-028 A reset during CONV or DONE SHALL discard the word in flight. No out_valid pulse SHALL follow reset deassertion.
REQ-029 The first accept after reset deassertion SHALL be possible on the first rising edge with in_valid=1.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, CONV=2'd1, DONE=2'd2), XS3_OFFSET=4'd3 and XS3_INVALID=4'hF.
REQ-031 Per-digit conversion SHALL be one combinational sub-module, bcd_digit_xs3, with input a 4-bit digit and outputs a 4-bit excess-3 code and a 1-bit invalid flag. It SHALL be instantiated once and time-shared across digits by the FSM.
REQ-032 The state value 2'd3 SHALL be unreachable. If reached, the FSM SHALL return to IDLE on the next edge.

Verification
REQ-033 Accept in_bcd=16'h1234 with NDIGITS=4 and out_ready=1 -> out_xs3=16'h4567, out_err=0; out_valid first high 5 cycles after the accept edge, high for 1 cycle.
REQ-034 Boundary digits: 16'h0000 -> 16'h3333; 16'h9999 -> 16'hCCCC; both with out_err=0.
REQ-035 Invalid digit: 16'h12A4 -> 16'h45F7, out_err=1. The next word 16'h0001 -> 16'h3334, out_err=0, so the error flag is cleared per word.
REQ-036 Backpressure: hold out_ready=0 for 6 cycles in DONE -> out_valid, out_xs3 and out_err stable, in_ready=0, and in_bcd changes ignored. Then out_ready=1 -> IDLE the next cycle.
REQ-037 Assert rst in the 2nd CONV cycle of word 16'h5678 -> outputs go immediately to their reset values, no out_valid pulse follows. The next word 16'h0042 -> 16'h3375.
REQ-038 Back-to-back: in_valid held high with two words queued -> accept edges exactly NDIGITS+2 cycles apart, and both results correct and in order.
